// File: rtl/led_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_pkg
// Description : Shared constants and brightness type for the LED PWM fader.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;
    localparam int N_LED      = 4;
    localparam int PWM_BITS   = 8;
    localparam int MAX_BRIGHT = 2**PWM_BITS - 1;
    localparam int STEP       = 32;
    localparam int STEP_DIV   = 4;

    typedef logic [PWM_BITS-1:0] brightness_t;
endpackage
`default_nettype wire

// File: rtl/led_fade_channel.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_fade_channel
// Description : One LED channel: saturating brightness ramp and PWM compare.
// Revision    : 1.0 - initial release
// ============================================================================
module led_fade_channel #(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                step_tick,
    input  logic                target_on,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm,
    output logic                at_target
);
    localparam logic [PWM_BITS-1:0] c_MAX    = '1;
    localparam logic [PWM_BITS-1:0] c_STEP   = PWM_BITS'(STEP);
    localparam logic [PWM_BITS:0]   c_STEP_W = (PWM_BITS+1)'(STEP);

    logic [PWM_BITS-1:0] r_bright;
    logic                r_pwm;
    logic [PWM_BITS-1:0] w_target;
    logic [PWM_BITS-1:0] w_bright_next;
    logic [PWM_BITS:0]   w_sum;

    // One extra bit on the sum so the upward step can clamp at full scale.
    always_comb begin
        w_target      = target_on ? c_MAX : '0;
        w_sum         = {1'b0, r_bright} + c_STEP_W;
        w_bright_next = r_bright;
        if (r_bright < w_target) begin
            w_bright_next = (w_sum > {1'b0, c_MAX}) ? c_MAX : w_sum[PWM_BITS-1:0];
        end else if (r_bright > w_target) begin
            w_bright_next = (r_bright < c_STEP) ? '0 : (r_bright - c_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bright <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (step_tick) begin
                r_bright <= w_bright_next;
            end
            r_pwm <= en && (r_bright > pwm_cnt);
        end
    end

    assign pwm       = r_pwm;
    assign at_target = (r_bright == w_target);
endmodule
`default_nettype wire

// File: rtl/led_pwm_fader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : led_pwm_fader
// Description : Turns chaser on/off levels into smoothly faded PWM LED drive.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_fader #(
    parameter int N_LED    = led_pkg::N_LED,
    parameter int PWM_BITS = led_pkg::PWM_BITS,
    parameter int STEP     = led_pkg::STEP,
    parameter int STEP_DIV = led_pkg::STEP_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_LED-1:0] led_in,
    output logic [N_LED-1:0] pwm_out,
    output logic             period_start,
    output logic             busy
);
    localparam logic [PWM_BITS-1:0] c_CNT_LAST = PWM_BITS'(2**PWM_BITS - 2);
    localparam int                  c_DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(STEP_DIV - 1);

    logic [N_LED-1:0]    r_led_q;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic                r_period_start;
    logic                r_busy;
    logic                w_wrap;
    logic                w_step_tick;
    logic [N_LED-1:0]    w_at_target;

    // Counter stops one short of full scale so a full-scale channel stays lit.
    assign w_wrap      = en && (r_pwm_cnt == c_CNT_LAST);
    assign w_step_tick = w_wrap && (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led_q        <= '0;
            r_pwm_cnt      <= '0;
            r_div_cnt      <= '0;
            r_period_start <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_led_q        <= led_in;
            r_period_start <= en && (r_pwm_cnt == '0);
            r_busy         <= ~&w_at_target;
            if (en) begin
                r_pwm_cnt <= w_wrap ? '0 : (r_pwm_cnt + 1'b1);
            end
            if (w_wrap) begin
                r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : (r_div_cnt + 1'b1);
            end
        end
    end

    generate
        for (genvar i = 0; i < N_LED; i++) begin : g_ch
            led_fade_channel #(
                .PWM_BITS (PWM_BITS),
                .STEP     (STEP)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .step_tick (w_step_tick),
                .target_on (r_led_q[i]),
                .pwm_cnt   (r_pwm_cnt),
                .pwm       (pwm_out[i]),
                .at_target (w_at_target[i])
            );
        end
    endgenerate

    assign period_start = r_period_start;
    assign busy         = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_led_pwm_fader
// Description : Self-checking bench for led_pwm_fader against a brightness model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_fader;
    import led_pkg::*;

    localparam int c_PERIOD = MAX_BRIGHT;
    localparam int c_TICK   = MAX_BRIGHT * STEP_DIV;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b0;
    logic [N_LED-1:0] led_in = '0;
    logic [N_LED-1:0] pwm_out;
    logic             period_start;
    logic             busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_bright [N_LED];
    logic [N_LED-1:0] m_ledq;
    int          m_run;

    always #1 clk = ~clk;

    led_pwm_fader u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .led_in       (led_in),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_LED; i++) m_bright[i] = 0;
        m_ledq = '0;
        m_run  = 0;
    endtask

    // Model works on total enabled cycles: phase within a period and tick position
    // both fall out of simple modular arithmetic on that count.
    task automatic step();
        logic [N_LED-1:0] exp_pwm;
        logic             exp_ps;
        logic             exp_busy;
        int               phase;
        int               tgt;
        @(posedge clk);
        exp_pwm  = '0;
        exp_ps   = 1'b0;
        exp_busy = 1'b0;
        if (!rst) begin
            model_reset();
        end else begin
            phase  = m_run % c_PERIOD;
            exp_ps = en && (phase == 0);
            for (int i = 0; i < N_LED; i++) begin
                tgt = m_ledq[i] ? MAX_BRIGHT : 0;
                exp_pwm[i] = en && (m_bright[i] > phase);
                if (m_bright[i] != tgt) exp_busy = 1'b1;
            end
            if (en && (m_run % c_TICK == c_TICK - 1)) begin
                for (int i = 0; i < N_LED; i++) begin
                    tgt = m_ledq[i] ? MAX_BRIGHT : 0;
                    if (m_bright[i] < tgt)
                        m_bright[i] = (m_bright[i] + STEP > MAX_BRIGHT) ? MAX_BRIGHT : m_bright[i] + STEP;
                    else if (m_bright[i] > tgt)
                        m_bright[i] = (m_bright[i] < STEP) ? 0 : m_bright[i] - STEP;
                end
            end
            m_ledq = led_in;
            if (en) m_run = (m_run + 1) % c_TICK;
        end
        #1;
        check_eq("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        check_eq("period_start", 32'(period_start), 32'(exp_ps));
        check_eq("busy", 32'(busy), 32'(exp_busy));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_eq("async_rst_pwm", 32'(pwm_out), 32'd0);
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        check_eq("async_rst_ps", 32'(period_start), 32'd0);
        model_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    // Counts high cycles of one channel across one full PWM period.
    task automatic measure_duty(input int ch, input int exp_duty);
        int ones;
        int waitc;
        waitc = 0;
        while (period_start !== 1'b1 && waitc < 2 * c_PERIOD) begin
            step();
            waitc++;
        end
        check_eq("period_start_timeout", 32'(waitc < 2 * c_PERIOD), 32'd1);
        ones = 0;
        for (int k = 0; k < c_PERIOD; k++) begin
            if (pwm_out[ch] === 1'b1) ones++;
            step();
        end
        check_eq($sformatf("duty_ch%0d", ch), 32'(ones), 32'(exp_duty));
    endtask

    initial begin
        int len;
        model_reset();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;

        // Full-on run then asynchronous reset
        en = 1'b1;
        led_in = 4'b1111;
        repeat (3000) step();
        do_reset();

        // Single channel fade up to full scale
        led_in = 4'b0001;
        repeat (1030) step();
        measure_duty(0, 32);
        measure_duty(1, 0);
        repeat (7 * c_TICK) step();
        measure_duty(0, MAX_BRIGHT);
        check_eq("busy_at_full", 32'(busy), 32'd0);

        // Fade up three ticks then back down
        do_reset();
        led_in = 4'b0001;
        repeat (3 * c_TICK + 10) step();
        measure_duty(0, 96);
        led_in = 4'b0000;
        repeat (c_TICK) step();
        measure_duty(0, 64);
        repeat (2 * c_TICK) step();
        check_eq("busy_after_down", 32'(busy), 32'd0);

        // Freeze mid-fade and resume
        do_reset();
        led_in = 4'b0001;
        repeat (4 * c_TICK + 10) step();
        en = 1'b0;
        repeat (500) step();
        en = 1'b1;
        measure_duty(0, 128);

        // Target applied one tick late when it lands on the tick cycle
        do_reset();
        led_in = 4'b0000;
        repeat (c_TICK - 1) step();
        led_in = 4'b0001;
        repeat (11) step();
        measure_duty(0, 0);
        repeat (600) step();
        measure_duty(0, 32);

        // Chaser sweep
        do_reset();
        for (int c = 0; c < N_LED; c++) begin
            led_in = N_LED'(1 << c);
            repeat (2 * c_TICK) step();
        end

        // Randomized levels, enable gaps and occasional resets
        for (int s = 0; s < 40; s++) begin
            led_in = N_LED'($urandom_range(0, 15));
            en     = ($urandom_range(0, 4) != 0);
            len    = $urandom_range(100, 1500);
            if ($urandom_range(0, 15) == 0) do_reset();
            repeat (len) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
